dbg_loader: RTL and testbench

UART-driven debug loader controller for the cvrisc SoC. Parses a byte stream from the UART receiver into commands, sequences the SoC debug memory port (`dbg_mem_op`, `dbg_wren`, `dbg_adr`, `dbg_do`) to write program/data words while the CPU is halted, and owns the CPU reset line. It is the hardware replacement for forcing the debug port from a bench: host tools download an image, then issue a run command.

---
 rtl/dbg_loader.sv | 224 ++++++++++++++++++++++
 tb/tb_dbg_loader.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dbg_loader.sv
// UART-driven debug loader: parses W/B/R/H/C commands and drives the SoC debug write port.
// Optional inter-byte timeout is enabled by defining DBG_LOADER_TIMEOUT_EN.
module dbg_loader #(
  parameter int WR_CYCLES      = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        cpu_n_reset,
  output logic        dbg_mem_op,
  output logic [3:0]  dbg_wren,
  output logic [31:0] dbg_adr,
  output logic [31:0] dbg_do,
  output logic        busy,
  output logic        err
);

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_B = 8'h42;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_H = 8'h48;
  localparam logic [7:0] CMD_C = 8'h43;
  localparam int         WCW   = $clog2(WR_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, WRITE} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      idx_reg, idx_next;
  logic            is_word_reg, is_word_next;
  logic [31:0]     adr_buf_reg, adr_buf_next;
  logic [23:0]     dat_buf_reg, dat_buf_next;
  logic [WCW-1:0]  wr_cnt_reg, wr_cnt_next;
  logic            cpu_n_reset_reg, cpu_n_reset_next;
  logic            mem_op_reg, mem_op_next;
  logic [3:0]      wren_reg, wren_next;
  logic [31:0]     adr_reg, adr_next;
  logic [31:0]     do_reg, do_next;
  logic            busy_reg, busy_next;
  logic            err_reg, err_next;

  logic            collecting;
  logic            final_byte;
  logic            aligned;
  logic            write_ok;
  logic            wr_last;
  logic            timeout_hit;
  logic [31:0]     word_val;
  logic [3:0]      lane_val;

  assign collecting = (state_reg == ADDR) || (state_reg == DATA);
  assign final_byte = rx_valid && (state_reg == DATA) && (!is_word_reg || idx_reg == 2'd3);
  assign aligned    = !is_word_reg || (adr_buf_reg[1:0] == 2'b00);
  // A running CPU must never see its memory rewritten underneath it.
  assign write_ok   = aligned && !cpu_n_reset_reg;
  assign wr_last    = (wr_cnt_reg == WCW'(WR_CYCLES - 1));
  assign word_val   = is_word_reg ? {rx_data, dat_buf_reg} : {4{rx_data}};
  assign lane_val   = is_word_reg ? 4'hF : (4'b0001 << adr_buf_reg[1:0]);

`ifdef DBG_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_reg;

  // Holds the number of cycles since the most recent byte while collecting.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      tmo_cnt_reg <= '0;
    end else if (rx_valid) begin
      tmo_cnt_reg <= TW'(1);
    end else if (collecting) begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end else begin
      tmo_cnt_reg <= '0;
    end
  end

  assign timeout_hit = collecting && !rx_valid && (tmo_cnt_reg >= TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_reg       <= IDLE;
      idx_reg         <= 2'd0;
      is_word_reg     <= 1'b0;
      adr_buf_reg     <= '0;
      dat_buf_reg     <= '0;
      wr_cnt_reg      <= '0;
      cpu_n_reset_reg <= 1'b0;
      mem_op_reg      <= 1'b0;
      wren_reg        <= 4'h0;
      adr_reg         <= '0;
      do_reg          <= '0;
      busy_reg        <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      is_word_reg     <= is_word_next;
      adr_buf_reg     <= adr_buf_next;
      dat_buf_reg     <= dat_buf_next;
      wr_cnt_reg      <= wr_cnt_next;
      cpu_n_reset_reg <= cpu_n_reset_next;
      mem_op_reg      <= mem_op_next;
      wren_reg        <= wren_next;
      adr_reg         <= adr_next;
      do_reg          <= do_next;
      busy_reg        <= busy_next;
      err_reg         <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (rx_valid && (rx_data == CMD_W || rx_data == CMD_B)) begin
          state_next = ADDR;
        end
      end
      ADDR: begin
        if (timeout_hit) begin
          state_next = IDLE;
        end else if (rx_valid && idx_reg == 2'd3) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (timeout_hit) begin
          state_next = IDLE;
        end else if (final_byte) begin
          state_next = write_ok ? WRITE : IDLE;
        end
      end
      WRITE: begin
        if (wr_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    idx_next         = idx_reg;
    is_word_next     = is_word_reg;
    adr_buf_next     = adr_buf_reg;
    dat_buf_next     = dat_buf_reg;
    wr_cnt_next      = wr_cnt_reg;
    cpu_n_reset_next = cpu_n_reset_reg;
    mem_op_next      = 1'b0;
    wren_next        = 4'h0;
    adr_next         = adr_reg;
    do_next          = do_reg;
    err_next         = err_reg;
    busy_next        = (state_next != IDLE);

    case (state_reg)
      IDLE: begin
        if (rx_valid) begin
          idx_next = 2'd0;
          case (rx_data)
            CMD_W:   is_word_next = 1'b1;
            CMD_B:   is_word_next = 1'b0;
            CMD_R:   cpu_n_reset_next = 1'b1;
            CMD_H:   cpu_n_reset_next = 1'b0;
            CMD_C:   err_next = 1'b0;
            default: err_next = 1'b1;
          endcase
        end
      end
      ADDR: begin
        if (rx_valid) begin
          adr_buf_next = {rx_data, adr_buf_reg[31:8]};
          idx_next     = idx_reg + 2'd1;
        end
      end
      DATA: begin
        if (rx_valid) begin
          dat_buf_next = {rx_data, dat_buf_reg[23:8]};
          idx_next     = idx_reg + 2'd1;
        end
        // Payload is always consumed; a rejected write only flags the error.
        if (final_byte) begin
          if (write_ok) begin
            mem_op_next = 1'b1;
            wren_next   = lane_val;
            adr_next    = adr_buf_reg;
            do_next     = word_val;
            wr_cnt_next = '0;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      WRITE: begin
        if (rx_valid) begin
          err_next = 1'b1;
        end
        if (!wr_last) begin
          mem_op_next = 1'b1;
          wren_next   = wren_reg;
          wr_cnt_next = wr_cnt_reg + 1'b1;
        end
      end
      default: ;
    endcase

    if (timeout_hit) begin
      err_next = 1'b1;
    end
  end

  assign cpu_n_reset = cpu_n_reset_reg;
  assign dbg_mem_op  = mem_op_reg;
  assign dbg_wren    = wren_reg;
  assign dbg_adr     = adr_reg;
  assign dbg_do      = do_reg;
  assign busy        = busy_reg;
  assign err         = err_reg;

endmodule

// File: tb/tb_dbg_loader.sv
// Directed bench for dbg_loader: command table plus hand sequences for overrun, reset and timeout.
module tb_dbg_loader;
  localparam int WR  = 4;
  localparam int TMO = 50;
  localparam int NV  = 14;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        cpu_n_reset;
  logic        dbg_mem_op;
  logic [3:0]  dbg_wren;
  logic [31:0] dbg_adr;
  logic [31:0] dbg_do;
  logic        busy;
  logic        err;

  dbg_loader #(.WR_CYCLES(WR), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .n_reset(n_reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .cpu_n_reset(cpu_n_reset), .dbg_mem_op(dbg_mem_op), .dbg_wren(dbg_wren),
    .dbg_adr(dbg_adr), .dbg_do(dbg_do), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:8][7:0] b;
    int              n;
    bit              pulse;
    logic [31:0]     adr;
    logic [31:0]     dat;
    logic [3:0]      wren;
    bit              err;
    bit              cpu;
  } vec_t;

  vec_t vecs [NV];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Bytes go out back-to-back; returns at the sample point of the cycle after the last byte.
  task automatic send_bytes(input logic [0:8][7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b[i];
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    int          pulses;
    int          first;
    logic [31:0] cap_adr;
    logic [31:0] cap_do;
    logic [3:0]  cap_wren;

    vecs[0]  = '{{8'h57,8'h00,8'h00,8'h02,8'h00,8'h23,8'ha0,8'h07,8'h00}, 9, 1'b1, 32'h00020000, 32'h0007a023, 4'hF, 1'b0, 1'b0};
    vecs[1]  = '{{8'h42,8'h02,8'h00,8'h01,8'h00,8'hAB,8'h00,8'h00,8'h00}, 6, 1'b1, 32'h00010002, 32'hABABABAB, 4'h4, 1'b0, 1'b0};
    vecs[2]  = '{{8'h42,8'h03,8'h00,8'h00,8'h10,8'h5C,8'h00,8'h00,8'h00}, 6, 1'b1, 32'h10000003, 32'h5C5C5C5C, 4'h8, 1'b0, 1'b0};
    vecs[3]  = '{{8'h42,8'h00,8'h00,8'h00,8'h00,8'h01,8'h00,8'h00,8'h00}, 6, 1'b1, 32'h00000000, 32'h01010101, 4'h1, 1'b0, 1'b0};
    vecs[4]  = '{{8'h57,8'h01,8'h00,8'h02,8'h00,8'h11,8'h22,8'h33,8'h44}, 9, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0};
    vecs[5]  = '{{8'h43,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0};
    vecs[6]  = '{{8'h52,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1};
    vecs[7]  = '{{8'h57,8'h00,8'h01,8'h00,8'h00,8'h11,8'h22,8'h33,8'h44}, 9, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1};
    vecs[8]  = '{{8'h43,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1};
    vecs[9]  = '{{8'h48,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0};
    vecs[10] = '{{8'h99,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0};
    vecs[11] = '{{8'h43,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0};
    vecs[12] = '{{8'h57,8'h48,8'h52,8'h00,8'h00,8'h52,8'h48,8'h52,8'h48}, 9, 1'b1, 32'h00005248, 32'h48524852, 4'hF, 1'b0, 1'b0};
    vecs[13] = '{{8'h42,8'h01,8'h00,8'h00,8'h80,8'h7E,8'h00,8'h00,8'h00}, 6, 1'b1, 32'h80000001, 32'h7E7E7E7E, 4'h2, 1'b0, 1'b0};

    n_reset  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cpu", {31'b0, cpu_n_reset}, 32'h0);
    check("rst_memop", {31'b0, dbg_mem_op}, 32'h0);
    check("rst_wren", {28'b0, dbg_wren}, 32'h0);
    check("rst_adr", dbg_adr, 32'h0);
    check("rst_do", dbg_do, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);
    n_reset = 1'b1;
    @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      send_bytes(vecs[v].b, vecs[v].n);
      pulses = 0;
      first  = -1;
      cap_adr = 32'h0; cap_do = 32'h0; cap_wren = 4'h0;
      check($sformatf("v%0d_busy_n1", v), {31'b0, busy}, {31'b0, vecs[v].pulse});
      for (int i = 0; i < WR + 2; i++) begin
        if (i > 0) @(negedge clk);
        if (dbg_mem_op) begin
          pulses++;
          if (first < 0) first = i;
          cap_adr = dbg_adr; cap_do = dbg_do; cap_wren = dbg_wren;
        end
      end
      check($sformatf("v%0d_pulses", v), pulses, vecs[v].pulse ? WR : 0);
      if (vecs[v].pulse) begin
        check($sformatf("v%0d_first", v), first, 32'd0);
        check($sformatf("v%0d_adr", v), cap_adr, vecs[v].adr);
        check($sformatf("v%0d_do", v), cap_do, vecs[v].dat);
        check($sformatf("v%0d_wren", v), {28'b0, cap_wren}, {28'b0, vecs[v].wren});
      end
      check($sformatf("v%0d_err", v), {31'b0, err}, {31'b0, vecs[v].err});
      check($sformatf("v%0d_cpu", v), {31'b0, cpu_n_reset}, {31'b0, vecs[v].cpu});
      check($sformatf("v%0d_busy_end", v), {31'b0, busy}, 32'h0);
      $display("vec %0d: cmd 0x%02h pulses %0d err %0b cpu %0b", v, vecs[v].b[0], pulses, err, cpu_n_reset);
    end

    // Overrun during WRITE, then a command in the earliest accepted cycle.
    send_bytes({8'h57,8'h40,8'h00,8'h00,8'h00,8'hEF,8'hBE,8'hAD,8'hDE}, 9);
    check("ovr_memop_n1", {31'b0, dbg_mem_op}, 32'h1);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h11;
    @(negedge clk);
    rx_valid = 1'b0;
    check("ovr_err", {31'b0, err}, 32'h1);
    check("ovr_memop_n3", {31'b0, dbg_mem_op}, 32'h1);
    check("ovr_do", dbg_do, 32'hDEADBEEF);
    check("ovr_adr", dbg_adr, 32'h00000040);
    @(negedge clk);
    check("ovr_memop_n4", {31'b0, dbg_mem_op}, 32'h1);
    @(negedge clk);
    check("ovr_memop_n5", {31'b0, dbg_mem_op}, 32'h0);
    check("ovr_busy_n5", {31'b0, busy}, 32'h0);
    rx_valid = 1'b1;
    rx_data  = 8'h43;
    @(negedge clk);
    rx_valid = 1'b0;
    check("ovr_clear", {31'b0, err}, 32'h0);
    $display("seq overrun: err cleared %0b", !err);

    // Reset asserted in the middle of a write.
    send_bytes({8'h57,8'h80,8'h00,8'h00,8'h00,8'h01,8'h02,8'h03,8'h04}, 9);
    check("mid_memop_n1", {31'b0, dbg_mem_op}, 32'h1);
    @(negedge clk);
    n_reset = 1'b0;
    @(negedge clk);
    check("mid_memop", {31'b0, dbg_mem_op}, 32'h0);
    check("mid_wren", {28'b0, dbg_wren}, 32'h0);
    check("mid_busy", {31'b0, busy}, 32'h0);
    check("mid_cpu", {31'b0, cpu_n_reset}, 32'h0);
    check("mid_adr", dbg_adr, 32'h0);
    n_reset = 1'b1;
    @(negedge clk);
    $display("seq reset mid-write: mem_op %0b", dbg_mem_op);

`ifdef DBG_LOADER_TIMEOUT_EN
    begin
      int saw_op;
      saw_op = 0;
      send_bytes({8'h57,8'h10,8'h20,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 3);
      for (int k = 2; k < TMO; k++) begin
        @(negedge clk);
        if (dbg_mem_op) saw_op = 1;
      end
      check("tmo_busy_before", {31'b0, busy}, 32'h1);
      @(negedge clk);
      check("tmo_busy", {31'b0, busy}, 32'h0);
      check("tmo_err", {31'b0, err}, 32'h1);
      check("tmo_noop", saw_op, 32'd0);
      $display("seq timeout: busy %0b err %0b", busy, err);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
